// File: rtl/m_store_buffer.sv
// M-stage store path: sw/sh/sb lane encoding, a DEPTH-entry store FIFO drained over req/ack, and load-vs-pending-store word hazard detection.
// Optional misaligned-store exception is enabled by defining STORE_ALIGN_CHK_EN.
module m_store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] instr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        st_stall,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic        mem_ack,
    output logic        exc_ades
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    typedef logic [PW-1:0] ptr_t;

    logic [29:0] r_addr [DEPTH];
    logic [3:0]  r_be   [DEPTH];
    logic [31:0] r_data [DEPTH];
    logic [31:0] r_pc   [DEPTH];
    ptr_t        r_head;
    ptr_t        r_tail;
    logic [PW:0] r_count;

    logic        w_is_sw;
    logic        w_is_sh;
    logic        w_is_sb;
    logic        w_is_st;
    logic        w_full;
    logic        w_exc;
    logic        w_push;
    logic        w_pop;
    logic        w_hit;
    logic [3:0]  w_be;
    logic [31:0] w_data;
    logic        w_unused;

    assign w_is_sw = (instr[31:26] == OP_SW);
    assign w_is_sh = (instr[31:26] == OP_SH);
    assign w_is_sb = (instr[31:26] == OP_SB);
    assign w_is_st = st_valid & (w_is_sw | w_is_sh | w_is_sb);
    assign w_unused = ^{instr[25:0], ld_addr[1:0]};

    always_comb begin
        w_be   = 4'b0000;
        w_data = wdata;
        if (w_is_sw) begin
            w_be   = 4'b1111;
            w_data = wdata;
        end else if (w_is_sh) begin
            w_be   = addr[1] ? 4'b1100 : 4'b0011;
            w_data = {2{wdata[15:0]}};
        end else if (w_is_sb) begin
            w_be   = 4'b0001 << addr[1:0];
            w_data = {4{wdata[7:0]}};
        end
    end

`ifdef STORE_ALIGN_CHK_EN
    assign w_exc = w_is_st & ((w_is_sw & (addr[1:0] != 2'b00)) | (w_is_sh & addr[0]));
`else
    assign w_exc = 1'b0;
`endif

    // A full buffer stalls even when the head is popping: there is no bypass path.
    assign w_full    = (r_count == FULL_CNT);
    assign st_stall  = w_is_st & w_full & ~w_exc;
    assign exc_ades  = w_exc;
    assign w_push    = w_is_st & ~w_full & ~w_exc;
    assign mem_req   = (r_count != '0);
    assign w_pop     = mem_req & mem_ack;

    assign mem_addr  = mem_req ? {r_addr[r_head], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? r_be[r_head]   : 4'h0;
    assign mem_wdata = mem_req ? r_data[r_head] : 32'h0;
    assign mem_pc    = mem_req ? r_pc[r_head]   : 32'h0;

    // An entry is live when its distance from the head is below the occupancy; a popping head still counts.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, ptr_t'(ptr_t'(i) - r_head)} < r_count) && (r_addr[i] == ld_addr[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_check & ~w_is_st & w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= addr[31:2];
                r_be[r_tail]   <= w_be;
                r_data[r_tail] <= w_data;
                r_pc[r_tail]   <= pc;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed scenarios plus a randomized run against a queue-based reference model.
// Misaligned-store checks follow STORE_ALIGN_CHK_EN when it is defined for the build.
module tb_m_store_buffer;

    localparam int DEPTH = 2;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_LW = 6'b100011;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        st_stall;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic        mem_ack;
    logic        exc_ades;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .instr(instr), .addr(addr),
        .wdata(wdata), .pc(pc), .st_stall(st_stall), .ld_check(ld_check), .ld_addr(ld_addr),
        .ld_hazard(ld_hazard), .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_ack(mem_ack), .exc_ades(exc_ades)
    );

    // Reference encoding: byte lane arithmetic straight from the store semantics.
    function automatic entry_t encode(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] d, input logic [31:0] p);
        entry_t e;
        int lane;
        lane   = int'(a % 4);
        e.addr = a - 32'(lane);
        e.pc   = p;
        if (op == OP_SW) begin
            e.be   = 4'hF;
            e.data = d;
        end else if (op == OP_SH) begin
            e.be   = (lane >= 2) ? 4'hC : 4'h3;
            e.data = {d[15:0], d[15:0]};
        end else begin
            e.be   = 4'(1 << lane);
            e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
        end
        return e;
    endfunction

    function automatic bit expExc(input logic [5:0] op, input logic [31:0] a);
`ifdef STORE_ALIGN_CHK_EN
        return ((op == OP_SW) && (a % 4 != 0)) || ((op == OP_SH) && (a % 2 != 0));
`else
        return (op == 6'h3F) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_valid = 1'b0;
        instr    = 32'h0;
        addr     = 32'h0;
        wdata    = 32'h0;
        pc       = 32'h0;
        ld_check = 1'b0;
        ld_addr  = 32'h0;
        mem_ack  = 1'b0;
    endtask

    task automatic driveStore(input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] p);
        st_valid = 1'b1;
        instr    = {op, 26'h0};
        addr     = a;
        wdata    = d;
        pc       = p;
    endtask

    task automatic doReset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset    = 1'b1;
        ld_check = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be, mem_wdata, mem_pc, ld_hazard, st_stall, exc_ades} !== 104'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got req=%0b addr=%h be=%b data=%h pc=%h hz=%0b stall=%0b exc=%0b want all zero",
                     mem_req, mem_addr, mem_be, mem_wdata, mem_pc, ld_hazard, st_stall, exc_ades);
        end
        idle();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sb_encode();
        driveStore(OP_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0000_0400);
        tick();
        idle();
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be, mem_wdata, mem_pc} !== {1'b1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 32'h400}) begin
            errors++;
            $display("[TB] FAIL sb_head got req=%0b addr=%h be=%b data=%h pc=%h want 1 00001000 1000 a5a5a5a5 00000400",
                     mem_req, mem_addr, mem_be, mem_wdata, mem_pc);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sb_drain got req=%0b want 0", mem_req);
        end
    endtask

    task automatic test_stall_order();
        driveStore(OP_SH, 32'h0000_2002, 32'h1234_BEEF, 32'h10);
        tick();
        driveStore(OP_SW, 32'h0000_2004, 32'hCAFE_F00D, 32'h14);
        tick();
        driveStore(OP_SB, 32'h0000_2005, 32'h0000_0077, 32'h18);
        #1;
        checks++;
        if ({st_stall, mem_addr, mem_be, mem_wdata, mem_pc} !== {1'b1, 32'h2000, 4'b1100, 32'hBEEFBEEF, 32'h10}) begin
            errors++;
            $display("[TB] FAIL full_stall got stall=%0b addr=%h be=%b data=%h pc=%h want 1 00002000 1100 beefbeef 00000010",
                     st_stall, mem_addr, mem_be, mem_wdata, mem_pc);
        end
        tick();
        #1;
        checks++;
        if ({st_stall, mem_addr, mem_be, mem_wdata, mem_pc} !== {1'b1, 32'h2000, 4'b1100, 32'hBEEFBEEF, 32'h10}) begin
            errors++;
            $display("[TB] FAIL head_stable got stall=%0b addr=%h be=%b data=%h pc=%h want 1 00002000 1100 beefbeef 00000010",
                     st_stall, mem_addr, mem_be, mem_wdata, mem_pc);
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (st_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_popping_stall got %0b want 1", st_stall);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (st_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release got %0b want 0", st_stall);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be, mem_wdata, mem_pc} !== {1'b1, 32'h2004, 4'b1111, 32'hCAFEF00D, 32'h14}) begin
            errors++;
            $display("[TB] FAIL order_second got req=%0b addr=%h be=%b data=%h pc=%h want 1 00002004 1111 cafef00d 00000014",
                     mem_req, mem_addr, mem_be, mem_wdata, mem_pc);
        end
        mem_ack = 1'b1;
        tick();
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be, mem_wdata, mem_pc} !== {1'b1, 32'h2004, 4'b0010, 32'h77777777, 32'h18}) begin
            errors++;
            $display("[TB] FAIL order_third got req=%0b addr=%h be=%b data=%h pc=%h want 1 00002004 0010 77777777 00000018",
                     mem_req, mem_addr, mem_be, mem_wdata, mem_pc);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL order_empty got req=%0b want 0", mem_req);
        end
    endtask

    task automatic test_ld_hazard();
        driveStore(OP_SW, 32'h0000_3008, 32'h0BAD_F00D, 32'h20);
        tick();
        st_valid = 1'b0;
        ld_check = 1'b1;
        ld_addr  = 32'h0000_300B;
        #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hazard_same_word got %0b want 1", ld_hazard);
        end
        ld_addr = 32'h0000_300C;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_next_word got %0b want 0", ld_hazard);
        end
        ld_addr = 32'h0000_300B;
        driveStore(OP_SW, 32'h0000_5000, 32'h0, 32'h24);
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_store_in_m got %0b want 0", ld_hazard);
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hazard_while_popping got %0b want 1", ld_hazard);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_after_ack got %0b want 0", ld_hazard);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        entry_t exp[$];
        entry_t head;
        logic [5:0] op;
        logic [31:0] a;
        int retired;
        retired = 0;
        mem_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_SW;
                1:       op = OP_SH;
                default: op = OP_SB;
            endcase
            a = $urandom;
            if (op == OP_SW) a = a & 32'hFFFF_FFFC;
            if (op == OP_SH) a = a & 32'hFFFF_FFFE;
            driveStore(op, a, $urandom, 32'h1000 + 32'(4 * k));
            #1;
            checks++;
            if (st_stall !== 1'b0 || mem_req !== (exp.size() > 0)) begin
                errors++;
                $display("[TB] FAIL b2b_flow[%0d] got stall=%0b req=%0b want stall=0 req=%0b",
                         k, st_stall, mem_req, exp.size() > 0);
            end
            if (exp.size() > 0) begin
                head = exp.pop_front();
                checks++;
                if ({mem_addr, mem_be, mem_wdata, mem_pc} !== head) begin
                    errors++;
                    $display("[TB] FAIL b2b_head[%0d] got %h want %h", k, {mem_addr, mem_be, mem_wdata, mem_pc}, head);
                end else begin
                    retired++;
                end
            end
            exp.push_back(encode(op, a, wdata, pc));
            tick();
        end
        st_valid = 1'b0;
        #1;
        head = exp.pop_front();
        checks++;
        if ({mem_req, mem_addr, mem_be, mem_wdata, mem_pc} !== {1'b1, head}) begin
            errors++;
            $display("[TB] FAIL b2b_last got %h want %h", {mem_req, mem_addr, mem_be, mem_wdata, mem_pc}, {1'b1, head});
        end else begin
            retired++;
        end
        tick();
        checks++;
        if (mem_req !== 1'b0 || retired != 20) begin
            errors++;
            $display("[TB] FAIL b2b_retired got req=%0b retired=%0d want req=0 retired=20", mem_req, retired);
        end
        idle();
    endtask

    task automatic test_reset_flush();
        driveStore(OP_SW, 32'h0000_7000, 32'h1111_1111, 32'h30);
        tick();
        driveStore(OP_SW, 32'h0000_7004, 32'h2222_2222, 32'h34);
        tick();
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_be} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL flush_after_reset got req=%0b be=%b want 0 0000", mem_req, mem_be);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stays_empty got req=%0b want 0", mem_req);
        end
        idle();
    endtask

    task automatic test_align();
`ifdef STORE_ALIGN_CHK_EN
        driveStore(OP_SW, 32'h0000_4002, 32'hDEAD_BEEF, 32'h40);
        #1;
        checks++;
        if ({exc_ades, st_stall} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ades_sw got exc=%0b stall=%0b want 1 0", exc_ades, st_stall);
        end
        tick();
        driveStore(OP_SH, 32'h0000_4001, 32'hDEAD_BEEF, 32'h44);
        #1;
        checks++;
        if ({exc_ades, mem_req} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ades_sh got exc=%0b req=%0b want 1 0", exc_ades, mem_req);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ades_no_push got req=%0b want 0", mem_req);
        end
`else
        driveStore(OP_SW, 32'h0000_4002, 32'hDEAD_BEEF, 32'h40);
        #1;
        checks++;
        if (exc_ades !== 1'b0) begin
            errors++;
            $display("[TB] FAIL noades_exc got %0b want 0", exc_ades);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h4000, 4'b1111, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL noades_write got req=%0b addr=%h be=%b data=%h want 1 00004000 1111 deadbeef",
                     mem_req, mem_addr, mem_be, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
`endif
        idle();
    endtask

    task automatic test_random();
        entry_t model[$];
        entry_t head;
        logic [5:0] op;
        bit isSt, eExc, eStall, eHit, eHaz, eReq;
        doReset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       op = OP_SW;
                1:       op = OP_SH;
                2:       op = OP_SB;
                3:       op = OP_LW;
                default: op = 6'h00;
            endcase
            st_valid = 1'($urandom_range(0, 1));
            instr    = {op, 26'($urandom)};
            addr     = 32'h0000_6000 + 32'($urandom_range(0, 31));
            wdata    = $urandom;
            pc       = $urandom;
            mem_ack  = ($urandom_range(0, 3) == 0);
            ld_check = 1'($urandom_range(0, 1));
            ld_addr  = 32'h0000_6000 + 32'($urandom_range(0, 31));
            #1;
            isSt   = st_valid && (op == OP_SW || op == OP_SH || op == OP_SB);
            eExc   = isSt && expExc(op, addr);
            eStall = isSt && (model.size() == DEPTH) && !eExc;
            eHit   = 1'b0;
            foreach (model[j]) if (model[j].addr / 4 == ld_addr / 4) eHit = 1'b1;
            eHaz   = ld_check && !isSt && eHit;
            eReq   = (model.size() > 0);
            head   = eReq ? model[0] : '0;
            checks++;
            if ({st_stall, ld_hazard, exc_ades, mem_req} !== {eStall, eHaz, eExc, eReq}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl[%0d] got stall/hz/exc/req=%b want %b", n,
                         {st_stall, ld_hazard, exc_ades, mem_req}, {eStall, eHaz, eExc, eReq});
            end
            checks++;
            if ({mem_addr, mem_be, mem_wdata, mem_pc} !== head) begin
                errors++;
                $display("[TB] FAIL rand_head[%0d] got %h want %h", n, {mem_addr, mem_be, mem_wdata, mem_pc}, head);
            end
            if (eReq && mem_ack) void'(model.pop_front());
            if (isSt && !eStall && !eExc) model.push_back(encode(op, addr, wdata, pc));
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_sb_encode();
        test_stall_order();
        test_ld_hazard();
        test_back_to_back();
        test_reset_flush();
        test_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_store_buffer.md
# m_store_buffer

Memory-stage store path for the pipelined MIPS core. It decodes `sw`/`sh`/`sb`, turns byte address and register data into a word-aligned address, a 4-bit byte-enable and lane-replicated write data, and queues the result in a small FIFO. The FIFO drains to the data memory over a req/ack handshake. The block also flags loads in M that hit a word still pending in the buffer, so the hazard unit can stall them.

## Interface
- `DEPTH`, 2: number of buffer entries (power of two, ≥2).
- `clk  in  1`: core clock.
- `reset  in  1`: synchronous, active-high reset.
- `st_valid  in  1`: the M-stage instruction is valid this cycle.
- `instr  in  32`: M-stage instruction; opcode in `instr[31:26]`.
- `addr  in  32`: store byte address (ALU result).
- `wdata  in  32`: rt register value.
- `pc  in  32`: PC of the M-stage instruction.
- `st_stall  out  1`: hold M stage; the store cannot be accepted this cycle.
- `ld_check  in  1`: the M-stage instruction is a load.
- `ld_addr  in  32`: load byte address.
- `ld_hazard  out  1`: the load word matches a pending buffered store.
- `mem_req  out  1`: head entry is valid.
- `mem_addr  out  32`: head word address, `[1:0]`=0.
- `mem_be  out  4`: head byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_wdata  out  32`: head write data.
- `mem_pc  out  32`: head store PC, for the write trace.
- `mem_ack  in  1`: memory accepted the head this cycle.
- `exc_ades  out  1`: misaligned-store exception (see Configuration).

## Operation
- Opcodes: `sw`=101011, `sh`=101001, `sb`=101000. Any other opcode is ignored; `st_stall` stays 0 for it.
- `is_st = st_valid & store opcode`.
- Encoding, with `a = addr[1:0]`:
  - `sw`: be=1111, data=`wdata`.
  - `sh`: be=0011 if `a[1]`=0, else 1100; data=`{2{wdata[15:0]}}`.
  - `sb`: be=`0001<<a`; data=`{4{wdata[7:0]}}`.
  - Stored address is `{addr[31:2],2'b00}`.
- Push: `is_st & ~st_stall & ~exc_ades`. Entry = {addr, be, data, pc}.
- Pop: `mem_req & mem_ack`.
- `st_stall = is_st & (count==DEPTH)`. It is combinational, and full-and-popping still stalls (no pass-through).
- Push and pop in the same cycle: count is unchanged and order is preserved.
- `mem_*` show the head entry. They must stay stable while `mem_req & ~mem_ack`.
- `mem_ack` with `mem_req`=0 is ignored.
- `ld_hazard = ld_check & ~st_valid-store & (∃ valid entry: entry.addr[31:2]==ld_addr[31:2])`.
  - Comparison is word-granular, regardless of be.
  - An entry popping this cycle still counts.
- Pointers wrap modulo DEPTH. Count has `log2(DEPTH)+1` bits.

## Timing
- Reset values: `count`=0, `mem_req`=0, `mem_addr`/`mem_be`/`mem_wdata`/`mem_pc`=0, `ld_hazard`=0, `st_stall`=0, `exc_ades`=0.
- Store accepted at edge N into an empty buffer gives `mem_req`=1 from cycle N+1.
- With ack held high, throughput is one store per cycle.
- `st_stall`, `ld_hazard` and `exc_ades` are combinational from inputs and current state; there is no registered latency.
- Reset mid-transaction flushes all entries; pending stores are dropped. `mem_ack` during reset is ignored.
- Occupancy steps: empty→1 on push-only; DEPTH-1→DEPTH on push-only; DEPTH→DEPTH-1 on pop (the stalled store pushes the next cycle).

## Configuration
- `STORE_ALIGN_CHK_EN` defined:
  - `exc_ades` = `is_st & ((sw & a≠0) | (sh & a[0]))`.
  - The faulting store is not pushed and `st_stall` is forced 0 for it.
- Not defined:
  - `exc_ades` is tied 0.
  - Address bits below access size are ignored: `sw` uses the word, `sh` uses `a[1]` only.

## Test plan
- Reset, then `sb` addr=0x1003 wdata=0x000000A5 → next cycle `mem_req`=1, `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- `sh` addr=0x2002 wdata=0x1234BEEF, then `sw` addr=0x2004, with `mem_ack`=0 → head holds be=1100 and data 0xBEEFBEEF, stable. A third store raises `st_stall`=1. Ack once → the stalled store is accepted the next cycle, and order is sh, sw, third.
- Buffer holds a store to 0x3008; `ld_check` with `ld_addr`=0x300B → `ld_hazard`=1. With 0x300C → 0. After the ack of 0x3008 → 0.
- Simultaneous push and ack with count=1 over 20 back-to-back stores, ack always 1 → `count` stays ≤1, all 20 retire in order, `st_stall` never asserts.
- Reset while full with ack=1 → the next cycle has `mem_req`=0 and nothing is written.
- With `STORE_ALIGN_CHK_EN`: `sw` addr=0x4002 → `exc_ades`=1, no push. `sh` addr=0x4001 → `exc_ades`=1. Without it: `sw` 0x4002 writes 0x4000 with be=1111.
